// File: rtl/grid_access_arbiter.sv
// rtl/grid_access_arbiter.sv - round-robin arbiter for the single-port placement grid RAM
// Serialises read, write and atomic claim (test-and-set against EMPTY) from NREQ workers.
module grid_access_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 32,
  parameter int AW         = 12,
  parameter int GRID_CELLS = 121,
  parameter int MEM_LAT    = 1,
  parameter logic signed [DW-1:0] EMPTY = -1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  op,
  input  logic [AW*NREQ-1:0] addr,
  input  logic [DW*NREQ-1:0] wdata,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               claim_ok,
  output logic               err,
  output logic               busy,
  output logic               mem_read,
  output logic               mem_write,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_din,
  input  logic [DW-1:0]      mem_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLAIM = 2'b10;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, WRITE, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   win, win_nxt;
  logic [1:0]      lat_op, lat_op_nxt;
  logic [DW-1:0]   lat_wdata, lat_wdata_nxt;
  logic [LW-1:0]   wcnt, wcnt_nxt;
  logic [NREQ-1:0] grant_nxt, done_nxt;
  logic [DW-1:0]   rdata_nxt, mem_din_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic            claim_ok_nxt, err_nxt, busy_nxt, mem_read_nxt, mem_write_nxt;

  logic [IW-1:0]   pick;
  logic            found;
  logic [1:0]      sel_op;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // Round-robin search starting at ptr; the first requester found wins.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign sel_op    = op[2*int'(pick) +: 2];
  assign sel_addr  = addr[AW*int'(pick) +: AW];
  assign sel_wdata = wdata[DW*int'(pick) +: DW];

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    win_nxt       = win;
    lat_op_nxt    = lat_op;
    lat_wdata_nxt = lat_wdata;
    wcnt_nxt      = wcnt;
    grant_nxt     = grant;
    done_nxt      = '0;
    rdata_nxt     = rdata;
    claim_ok_nxt  = claim_ok;
    err_nxt       = err;
    mem_read_nxt  = 1'b0;
    mem_write_nxt = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_din_nxt   = mem_din;

    case (state)
      IDLE: begin
        if (found) begin
          win_nxt       = pick;
          lat_op_nxt    = sel_op;
          lat_wdata_nxt = sel_wdata;
          grant_nxt     = NREQ'(1) << pick;
          mem_addr_nxt  = sel_addr;
          rdata_nxt     = '0;
          claim_ok_nxt  = 1'b0;
          err_nxt       = 1'b0;
          if (sel_addr >= AW'(GRID_CELLS)) begin
            err_nxt   = 1'b1;
            done_nxt  = NREQ'(1) << pick;
            state_nxt = DONE;
          end else begin
            state_nxt = ISSUE;
            if (sel_op == OP_WRITE) begin
              mem_write_nxt = 1'b1;
              mem_din_nxt   = sel_wdata;
            end else begin
              mem_read_nxt = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (lat_op == OP_WRITE) begin
          done_nxt  = grant;
          state_nxt = DONE;
        end else begin
          wcnt_nxt  = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == LW'(MEM_LAT - 1)) begin
          rdata_nxt = mem_dout;
          if (lat_op == OP_CLAIM) begin
            state_nxt = EVAL;
          end else begin
            done_nxt  = grant;
            state_nxt = DONE;
          end
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      EVAL: begin
        // Write is issued straight after the read; nothing else can reach the RAM in between.
        if (rdata == EMPTY) begin
          mem_write_nxt = 1'b1;
          mem_din_nxt   = lat_wdata;
          state_nxt     = WRITE;
        end else begin
          claim_ok_nxt = 1'b0;
          done_nxt     = grant;
          state_nxt    = DONE;
        end
      end
      WRITE: begin
        claim_ok_nxt = 1'b1;
        done_nxt     = grant;
        state_nxt    = DONE;
      end
      DONE: begin
        grant_nxt    = '0;
        err_nxt      = 1'b0;
        claim_ok_nxt = 1'b0;
        ptr_nxt      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      lat_op    <= '0;
      lat_wdata <= '0;
      wcnt      <= '0;
      grant     <= '0;
      done      <= '0;
      rdata     <= '0;
      claim_ok  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      win       <= win_nxt;
      lat_op    <= lat_op_nxt;
      lat_wdata <= lat_wdata_nxt;
      wcnt      <= wcnt_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      rdata     <= rdata_nxt;
      claim_ok  <= claim_ok_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_din   <= mem_din_nxt;
    end
  end

endmodule

// File: tb/tb_grid_access_arbiter.sv
// tb/tb_grid_access_arbiter.sv - directed vector bench for grid_access_arbiter
module tb_grid_access_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [7:0]    op;
  logic [47:0]   addr;
  logic [127:0]  wdata;
  logic [3:0]    grant, done;
  logic [31:0]   rdata;
  logic          claim_ok, err, busy, mem_read, mem_write;
  logic [11:0]   mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout = '0;
  logic [31:0]   ram [0:127] = '{default: 32'hFFFF_FFFF};

  int pass_cnt = 0;
  int total_cnt = 0;
  int overlap_cnt = 0;
  int long_cnt = 0;
  int wr10_cnt = 0;
  int wr_total = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  grid_access_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .grant(grant), .done(done), .rdata(rdata), .claim_ok(claim_ok), .err(err),
    .busy(busy), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) ram[mem_addr[6:0]] <= mem_din;
    if (mem_read) mem_dout <= ram[mem_addr[6:0]];
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap_cnt++;
    if ((mem_read && prev_rd) || (mem_write && prev_wr)) long_cnt++;
    if (mem_write) wr_total++;
    if (mem_write && mem_addr == 12'd10) wr10_cnt++;
    prev_rd = mem_read;
    prev_wr = mem_write;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int          who;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        ok;
    logic        err;
    int          nrd;
    int          nwr;
    int          wcyc;
  } vec_t;

  int          r_lat, r_nrd, r_nwr, r_rcyc, r_wcyc;
  logic [3:0]  r_done, r_grant;
  logic [31:0] r_rd, r_wdin;
  logic        r_ok, r_err;
  logic [11:0] r_waddr;

  // Entered and left on a negedge; cycle 0 is the one in which req is first sampled.
  task automatic run_txn(input int who, input logic [1:0] o, input logic [11:0] a, input logic [31:0] wd);
    r_lat = -1; r_nrd = 0; r_nwr = 0; r_rcyc = 0; r_wcyc = 0;
    r_done = '0; r_grant = '0; r_rd = '0; r_ok = 1'b0; r_err = 1'b0; r_waddr = '0; r_wdin = '0;
    op[2*who +: 2]     = o;
    addr[12*who +: 12] = a;
    wdata[32*who +: 32] = wd;
    req[who] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_read) begin r_nrd++; if (r_rcyc == 0) r_rcyc = c; end
      if (mem_write) begin r_nwr++; if (r_wcyc == 0) r_wcyc = c; r_waddr = mem_addr; r_wdin = mem_din; end
      if (done != 4'b0) begin
        r_lat = c; r_done = done; r_grant = grant; r_rd = rdata; r_ok = claim_ok; r_err = err;
        break;
      end
    end
    req[who] = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v == (4'b1 << i)) return i;
    return -1;
  endfunction

  vec_t vecs[9];
  logic [88:0] outs_acc;
  int          order[6];
  logic [31:0] rds[6];
  int          ndone, wbad, w10_base, wr_base, first_idx, second_idx;
  logic [31:0] first_rd, second_rd;
  logic        first_ok, second_ok;
  logic [31:0] exp_rd4[4];

  initial begin
    vecs[0] = '{2, 2'b10, 12'd60,   32'd7,  5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 1, 4};
    vecs[1] = '{0, 2'b00, 12'd60,   32'd0,  3, 1'b1, 32'd7,         1'b0, 1'b0, 1, 0, 0};
    vecs[2] = '{1, 2'b01, 12'd5,    32'd42, 2, 1'b0, 32'd0,         1'b0, 1'b0, 0, 1, 1};
    vecs[3] = '{3, 2'b00, 12'd5,    32'd0,  3, 1'b1, 32'd42,        1'b0, 1'b0, 1, 0, 0};
    vecs[4] = '{1, 2'b10, 12'd5,    32'd9,  4, 1'b1, 32'd42,        1'b0, 1'b0, 1, 0, 0};
    vecs[5] = '{3, 2'b01, 12'd121,  32'd5,  1, 1'b0, 32'd0,         1'b0, 1'b1, 0, 0, 0};
    vecs[6] = '{0, 2'b00, 12'd120,  32'd0,  3, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 0, 0};
    vecs[7] = '{2, 2'b10, 12'd4095, 32'd8,  1, 1'b0, 32'd0,         1'b0, 1'b1, 0, 0, 0};
    vecs[8] = '{1, 2'b11, 12'd60,   32'd0,  3, 1'b1, 32'd7,         1'b0, 1'b0, 1, 0, 0};

    reset = 1'b0; req = '0; op = '0; addr = '0; wdata = '0;

    // Reset state and 20 quiet cycles after release
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", {31'b0, |{grant, done, rdata, claim_ok, err, busy, mem_read, mem_write, mem_addr, mem_din}}, 32'd0);
    reset = 1'b1;
    outs_acc = '0;
    repeat (20) begin
      @(negedge clk);
      outs_acc = outs_acc | {grant, done, rdata, claim_ok, err, busy, mem_read, mem_write, mem_addr, mem_din};
    end
    chk("idle_20_cycles_zero", {31'b0, |outs_acc}, 32'd0);

    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].who, vecs[v].op, vecs[v].addr, vecs[v].wdata);
      chk($sformatf("v%0d latency", v), r_lat, vecs[v].lat);
      chk($sformatf("v%0d done", v), {28'b0, r_done}, 32'(4'b1 << vecs[v].who));
      chk($sformatf("v%0d grant", v), {28'b0, r_grant}, 32'(4'b1 << vecs[v].who));
      if (vecs[v].chk_rd) chk($sformatf("v%0d rdata", v), r_rd, vecs[v].rdata);
      chk($sformatf("v%0d claim_ok", v), {31'b0, r_ok}, {31'b0, vecs[v].ok});
      chk($sformatf("v%0d err", v), {31'b0, r_err}, {31'b0, vecs[v].err});
      chk($sformatf("v%0d reads", v), r_nrd, vecs[v].nrd);
      chk($sformatf("v%0d writes", v), r_nwr, vecs[v].nwr);
      if (vecs[v].nrd > 0) chk($sformatf("v%0d read_cycle", v), r_rcyc, 1);
      if (vecs[v].nwr > 0) begin
        chk($sformatf("v%0d write_cycle", v), r_wcyc, vecs[v].wcyc);
        chk($sformatf("v%0d write_addr", v), {20'b0, r_waddr}, {20'b0, vecs[v].addr});
        chk($sformatf("v%0d write_data", v), r_wdin, vecs[v].wdata);
      end
      @(negedge clk);
      chk($sformatf("v%0d back_to_idle", v), {21'b0, grant, done, busy, claim_ok, err}, 32'd0);
    end

    // Two simultaneous claims of the same free cell
    pulse_reset();
    w10_base = wr10_cnt;
    op = 8'b0000_1010; addr = {24'd0, 12'd10, 12'd10}; wdata = {64'd0, 32'd4, 32'd3};
    req = 4'b0011;
    ndone = 0; first_idx = -1; second_idx = -1;
    first_rd = '0; second_rd = '0; first_ok = 1'b0; second_ok = 1'b1;
    for (int c = 0; c < 40 && ndone < 2; c++) begin
      @(negedge clk);
      if (done != 4'b0) begin
        if (ndone == 0) begin first_idx = oh_idx(done); first_rd = rdata; first_ok = claim_ok; end
        else begin second_idx = oh_idx(done); second_rd = rdata; second_ok = claim_ok; end
        req = req & ~done;
        ndone++;
      end
    end
    req = '0;
    @(negedge clk);
    chk("race first winner", first_idx, 0);
    chk("race first claim_ok", {31'b0, first_ok}, 32'd1);
    chk("race first rdata", first_rd, 32'hFFFF_FFFF);
    chk("race second idx", second_idx, 1);
    chk("race second claim_ok", {31'b0, second_ok}, 32'd0);
    chk("race second rdata", second_rd, 32'd3);
    chk("race writes to 10", wr10_cnt - w10_base, 1);
    chk("race cell 10", ram[10], 32'd3);

    // All four requesters reading continuously
    pulse_reset();
    exp_rd4 = '{32'd7, 32'd42, 32'hFFFF_FFFF, 32'd7};
    op = 8'b0; addr = {12'd60, 12'd120, 12'd5, 12'd60}; wdata = '0;
    req = 4'b1111;
    ndone = 0; wbad = 0;
    for (int c = 0; c < 80 && ndone < 6; c++) begin
      @(negedge clk);
      if (done != 4'b0) begin
        if (ndone > 0 && order[ndone-1] >= 0 && prev_done_hi()) wbad++;
        order[ndone] = oh_idx(done);
        rds[ndone] = rdata;
        ndone++;
        if (ndone == 6) req = '0;
      end
    end
    req = '0;
    chk("rr done count", ndone, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr order %0d", i), order[i], i % 4);
      chk($sformatf("rr rdata %0d", i), rds[i], exp_rd4[i % 4]);
    end
    chk("rr done width", wbad, 0);
    @(negedge clk);

    // Reset during EVAL of a claim on a free cell
    wr_base = wr_total;
    op[3:2] = 2'b10; addr[23:12] = 12'd30; wdata[63:32] = 32'd11;
    req[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort busy before reset", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort outputs zero", {31'b0, |{grant, done, rdata, claim_ok, err, busy, mem_read, mem_write, mem_addr, mem_din}}, 32'd0);
    req = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort no write", wr_total - wr_base, 0);
    chk("abort cell 30", ram[30], 32'hFFFF_FFFF);
    run_txn(0, 2'b00, 12'd30, 32'd0);
    chk("abort readback latency", r_lat, 3);
    chk("abort readback rdata", r_rd, 32'hFFFF_FFFF);
    @(negedge clk);

    chk("strobe overlap", overlap_cnt, 0);
    chk("strobe width", long_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // done seen high on the previous negedge as well
  logic done_prev = 1'b0;
  always @(posedge clk) done_prev <= |done;
  function automatic logic prev_done_hi();
    return done_prev;
  endfunction

endmodule
